time_param_bank: RTL and testbench

Parametrised bank of programmable interval registers with an integrated countdown timer, for the traffic-light controller. Holds NUM_PARAMS time values (tBASE, tEXT, tYEL, …), each reloaded from a per-slot default on reset. Values are reprogrammed one slot at a time through a synchronised program pulse. The bank arms a countdown from any selected slot, decrements on the 1 Hz enable and flags expiry to the controller FSM.

---
 rtl/tlc_pkg.sv | 18 +
 rtl/time_param_bank_interval_counter.sv | 59 +++++
 rtl/time_param_bank.sv | 72 +++++++
 tb/tb_time_param_bank.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tlc_pkg : shared timer state encoding and slot indices for the TLC | rev 1.0
// ---------------------------------------------------------------------------
package tlc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } timer_state_e;

  localparam int T_BASE = 0;
  localparam int T_EXT  = 1;
  localparam int T_YEL  = 2;

endpackage
`default_nettype wire

// File: rtl/time_param_bank_interval_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// interval_counter : loadable seconds countdown with one-cycle expiry | rev 1.0
// ---------------------------------------------------------------------------
module interval_counter
  import tlc_pkg::*;
#(
  parameter int VAL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             tick,
  input  logic [VAL_W-1:0] load_val,
  output logic             busy,
  output logic             expired,
  output logic [VAL_W-1:0] remaining
);

  timer_state_e     state_q, state_d;
  logic [VAL_W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    // An arm always takes priority over a tick in the same cycle.
    if (start) begin
      count_d = load_val;
      state_d = (load_val != '0) ? COUNT : DONE;
    end else begin
      case (state_q)
        COUNT: begin
          if (tick) begin
            if (count_q != '0) count_d = count_q - 1'b1;
            if (count_q == VAL_W'(1)) state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy      = (state_q == COUNT);
  assign expired   = (state_q == DONE);
  assign remaining = count_q;

endmodule
`default_nettype wire

// File: rtl/time_param_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// time_param_bank : programmable interval slots feeding one countdown | rev 1.0
// ---------------------------------------------------------------------------
module time_param_bank
  import tlc_pkg::*;
#(
  parameter int                          NUM_PARAMS = 4,
  parameter int                          VAL_W      = 4,
  parameter int                          SEL_W      = $clog2(NUM_PARAMS),
  parameter logic [NUM_PARAMS*VAL_W-1:0] DEFAULTS   = {4'd0, 4'd2, 4'd3, 4'd6}
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             prog_sync,
  input  logic [SEL_W-1:0] time_parameter_selector,
  input  logic [VAL_W-1:0] time_value,
  input  logic [SEL_W-1:0] time_selector,
  output logic [VAL_W-1:0] value,
  input  logic             start_timer,
  input  logic             one_hz_enable,
  output logic             busy,
  output logic [VAL_W-1:0] remaining,
  output logic             expired,
  output logic             prog_ack
);

  logic [VAL_W-1:0] slot_q [NUM_PARAMS];
  logic [VAL_W-1:0] slot_d [NUM_PARAMS];
  logic             prog_ack_q, prog_ack_d;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_PARAMS; i++) slot_q[i] <= DEFAULTS[i*VAL_W +: VAL_W];
      prog_ack_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PARAMS; i++) slot_q[i] <= slot_d[i];
      prog_ack_q <= prog_ack_d;
    end
  end

  // Selector matching by loop keeps out-of-range selectors from ever indexing.
  always_comb begin
    prog_ack_d = 1'b0;
    value      = '0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      slot_d[i] = slot_q[i];
      if (prog_sync && (time_parameter_selector == SEL_W'(i))) begin
        slot_d[i]  = (time_value == '0) ? DEFAULTS[i*VAL_W +: VAL_W] : time_value;
        prog_ack_d = 1'b1;
      end
      if (time_selector == SEL_W'(i)) value = slot_q[i];
    end
  end

  assign prog_ack = prog_ack_q;

  interval_counter #(
    .VAL_W (VAL_W)
  ) u_counter (
    .clk       (clk),
    .rst_n     (Reset_n),
    .start     (start_timer),
    .tick      (one_hz_enable),
    .load_val  (value),
    .busy      (busy),
    .expired   (expired),
    .remaining (remaining)
  );

endmodule
`default_nettype wire

// File: tb/tb_time_param_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_time_param_bank : directed checks of slot bank and countdown | rev 1.0
// ---------------------------------------------------------------------------
module tb_time_param_bank;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       prog_sync, start_timer, one_hz_enable;
  logic [1:0] time_parameter_selector, time_selector;
  logic [3:0] time_value;
  logic [3:0] value, remaining;
  logic       busy, expired, prog_ack;

  // Three-slot instance for the out-of-range write selector case.
  logic       p3_sync;
  logic [1:0] p3_wsel, p3_rsel;
  logic [3:0] p3_tv, p3_value, p3_rem;
  logic       p3_busy, p3_exp, p3_ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  time_param_bank u_dut (
    .clk                     (clk),
    .Reset_n                 (Reset_n),
    .prog_sync               (prog_sync),
    .time_parameter_selector (time_parameter_selector),
    .time_value              (time_value),
    .time_selector           (time_selector),
    .value                   (value),
    .start_timer             (start_timer),
    .one_hz_enable           (one_hz_enable),
    .busy                    (busy),
    .remaining               (remaining),
    .expired                 (expired),
    .prog_ack                (prog_ack)
  );

  time_param_bank #(
    .NUM_PARAMS (3),
    .VAL_W      (4),
    .DEFAULTS   (12'h236)
  ) u_dut3 (
    .clk                     (clk),
    .Reset_n                 (Reset_n),
    .prog_sync               (p3_sync),
    .time_parameter_selector (p3_wsel),
    .time_value              (p3_tv),
    .time_selector           (p3_rsel),
    .value                   (p3_value),
    .start_timer             (1'b0),
    .one_hz_enable           (1'b0),
    .busy                    (p3_busy),
    .remaining               (p3_rem),
    .expired                 (p3_exp),
    .prog_ack                (p3_ack)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    one_hz_enable = 1'b1;
    step();
    one_hz_enable = 1'b0;
  endtask

  task automatic write(input logic [1:0] sel, input logic [3:0] tv);
    prog_sync = 1'b1; time_parameter_selector = sel; time_value = tv;
    step();
    prog_sync = 1'b0;
  endtask

  task automatic read(input string tag, input logic [1:0] sel, input logic [3:0] exp);
    time_selector = sel;
    #1;
    check_eq(tag, {12'd0, value}, {12'd0, exp});
  endtask

  task automatic timer(input string tag, input logic b, input logic e, input logic [3:0] r);
    check_eq({tag, "_busy"}, {15'd0, busy}, {15'd0, b});
    check_eq({tag, "_exp"},  {15'd0, expired}, {15'd0, e});
    check_eq({tag, "_rem"},  {12'd0, remaining}, {12'd0, r});
  endtask

  initial begin
    logic [3:0] dflt [4];
    dflt[0] = 4'd6; dflt[1] = 4'd3; dflt[2] = 4'd2; dflt[3] = 4'd0;

    Reset_n = 1'b0; prog_sync = 1'b0; start_timer = 1'b0; one_hz_enable = 1'b0;
    time_parameter_selector = 2'd0; time_value = 4'd0; time_selector = 2'd0;
    p3_sync = 1'b0; p3_wsel = 2'd0; p3_tv = 4'd0; p3_rsel = 2'd0;
    #12;
    timer("rst", 1'b0, 1'b0, 4'd0);
    check_eq("rst_ack", {15'd0, prog_ack}, 16'd0);
    for (int i = 0; i < 4; i++) read($sformatf("rst_slot%0d", i), 2'(i), dflt[i]);
    step();
    Reset_n = 1'b1;
    step();

    // Plain write with ack one cycle later.
    write(2'd0, 4'd8);
    check_eq("wr0_ack", {15'd0, prog_ack}, 16'd1);
    read("wr0_slot0", 2'd0, 4'd8);
    read("wr0_slot1", 2'd1, 4'd3);
    read("wr0_slot2", 2'd2, 4'd2);
    read("wr0_slot3", 2'd3, 4'd0);
    step();
    check_eq("wr0_ack_gone", {15'd0, prog_ack}, 16'd0);

    // Zero substitutes the default.
    write(2'd1, 4'd0);
    check_eq("wrz_ack", {15'd0, prog_ack}, 16'd1);
    read("wrz_slot1", 2'd1, 4'd3);

    // Out-of-range selector on the three-slot bank.
    p3_sync = 1'b1; p3_wsel = 2'd3; p3_tv = 4'd15;
    step();
    p3_sync = 1'b0;
    check_eq("oor_ack", {15'd0, p3_ack}, 16'd0);
    p3_rsel = 2'd0; #1; check_eq("oor_slot0", {12'd0, p3_value}, 16'd6);
    p3_rsel = 2'd1; #1; check_eq("oor_slot1", {12'd0, p3_value}, 16'd3);
    p3_rsel = 2'd2; #1; check_eq("oor_slot2", {12'd0, p3_value}, 16'd2);
    p3_rsel = 2'd3; #1; check_eq("oor_read3", {12'd0, p3_value}, 16'd0);
    p3_sync = 1'b1; p3_wsel = 2'd2; p3_tv = 4'd9;
    step();
    p3_sync = 1'b0;
    check_eq("p3_ack", {15'd0, p3_ack}, 16'd1);
    p3_rsel = 2'd2; #1; check_eq("p3_slot2", {12'd0, p3_value}, 16'd9);

    // Countdown of 2 from slot 2.
    time_selector = 2'd2; start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    timer("arm2", 1'b1, 1'b0, 4'd2);
    tick();
    timer("arm2_t1", 1'b1, 1'b0, 4'd1);
    step();
    timer("arm2_hold", 1'b1, 1'b0, 4'd1);
    tick();
    timer("arm2_t2", 1'b0, 1'b1, 4'd0);
    step();
    timer("arm2_idle", 1'b0, 1'b0, 4'd0);

    // Arming from a zero slot goes straight to DONE.
    time_selector = 2'd3; start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    timer("arm0", 1'b0, 1'b1, 4'd0);
    step();
    timer("arm0_idle", 1'b0, 1'b0, 4'd0);

    // Restart mid-count: start and tick together drops the tick.
    time_selector = 2'd0; start_timer = 1'b1;
    step();
    start_timer = 1'b0;
    timer("arm8", 1'b1, 1'b0, 4'd8);
    tick(); tick();
    timer("arm8_t2", 1'b1, 1'b0, 4'd6);
    write(2'd0, 4'd4);
    timer("wr_during_count", 1'b1, 1'b0, 4'd6);
    start_timer = 1'b1; one_hz_enable = 1'b1;
    step();
    start_timer = 1'b0; one_hz_enable = 1'b0;
    timer("rearm", 1'b1, 1'b0, 4'd4);
    tick(); tick(); tick();
    timer("rearm_t3", 1'b1, 1'b0, 4'd1);
    tick();
    timer("rearm_t4", 1'b0, 1'b1, 4'd0);
    step();

    // Write and arm on the same slot in one cycle: arm takes the old value.
    time_selector = 2'd1; start_timer = 1'b1;
    prog_sync = 1'b1; time_parameter_selector = 2'd1; time_value = 4'd5;
    step();
    start_timer = 1'b0; prog_sync = 1'b0;
    timer("wr_arm", 1'b1, 1'b0, 4'd3);
    read("wr_arm_slot1", 2'd1, 4'd5);

    // Asynchronous reset mid-count.
    #2;
    Reset_n = 1'b0;
    #1;
    timer("rst_mid", 1'b0, 1'b0, 4'd0);
    read("rst_mid_slot0", 2'd0, 4'd6);
    read("rst_mid_slot1", 2'd1, 4'd3);
    step(); step();
    timer("rst_hold", 1'b0, 1'b0, 4'd0);
    Reset_n = 1'b1;
    step();
    timer("rst_rel", 1'b0, 1'b0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
